branch_resolve_queue: RTL and testbench
=======================================

Name: branch_resolve_queue

Overview:
- Sits between the fetch-side predictor and the execute stage.
- Records every predicted branch at fetch in order, and compares each one with the actual outcome when execute resolves it.
- Produces a registered predictor-update record, a flush pulse and a redirect PC on misprediction.
- After a misprediction, holds fetch in a fixed bubble window before accepting new branches.

Parameters:
- PC_LEN, 32, width of PC and target fields.
- DEPTH, 4, in-flight branch entries; power of two, at least 2.
- FLUSH_CYCLES, 2, cycles spent in FLUSH state after a misprediction; at least 1.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- enq_valid  in  1  fetch presents a predicted branch.
- enq_ready  out  1  queue accepts an entry this cycle.
- enq_pc  in  PC_LEN  branch PC.
- enq_pred_taken  in  1  predicted direction.
- enq_pred_target  in  PC_LEN  predicted target.
- ex_valid  in  1  execute resolves the oldest branch.
- ex_pc  in  PC_LEN  resolved branch PC.
- ex_taken  in  1  actual direction.
- ex_target  in  PC_LEN  actual target.
- upd_valid  out  1  predictor update strobe.
- upd_pc  out  PC_LEN  update PC.
- upd_taken  out  1  update direction.
- upd_target  out  PC_LEN  update target.
- upd_mispred  out  1  the update is a misprediction.
- flush  out  1  one-cycle squash pulse.
- redirect_pc  out  PC_LEN  correct next fetch PC; valid while flush=1.
- occupancy  out  clog2(DEPTH)+1  entries held.
- err  out  2  sticky error flags; bit0 = underflow, bit1 = order mismatch.

Behaviour:
- Reset (rstn=0 at posedge):
  - queue emptied, state=RUN.
  - upd_valid=0, upd_mispred=0, flush=0, err=0.
  - upd_pc, upd_target, redirect_pc = 0; upd_taken=0; occupancy=0.
  - Reset mid-flush aborts the flush immediately.
- enq_ready = (state==RUN) && (occupancy<DEPTH). Combinational; must not depend on enq_valid.
- Enqueue occurs when enq_valid && enq_ready at posedge. Entry = {pc, pred_taken, pred_target}.
- Resolve: ex_valid in RUN with occupancy>0 pops the head entry.
- Mispredict = (head.pred_taken != ex_taken) || (ex_taken && head.pred_target != ex_target).
  - Not-taken branches ignore the target field.
- Registered outputs, 1-cycle latency: the cycle after a resolve,
  - upd_valid=1, upd_pc=ex_pc, upd_taken=ex_taken, upd_target=ex_target.
  - upd_mispred = mispredict.
  - upd_valid is high for exactly one cycle per resolve.
- On mispredict, the same cycle as upd_valid:
  - flush=1; redirect_pc = ex_taken ? ex_target : ex_pc+4, truncated to PC_LEN (wraps).
  - All remaining entries are discarded; occupancy=0.
  - State goes RUN -> FLUSH; the down-counter loads FLUSH_CYCLES.
- FLUSH state:
  - enq_ready=0 and ex_valid is ignored.
  - The counter decrements each cycle; at 1 -> RUN.
  - flush is high only in the first FLUSH cycle.
- Simultaneous enqueue and mispredicting resolve in the same cycle: the enqueue is younger, so it is dropped.
- Simultaneous enqueue and correct resolve: both happen; occupancy is unchanged.
  - When full, enq_ready stays 0 even if a pop happens the same cycle; there is no bypass.
- Pointers are clog2(DEPTH) bits and wrap naturally; occupancy is tracked separately.
- ex_valid with occupancy==0 in RUN:
  - sets err[0] and ignores the resolve; no update is produced.
- ex_pc != head.pc:
  - sets err[1] and still resolves against the head.
- err bits clear only on reset.

Optional Feature:
- Macro BRQ_STATS_EN.
- When defined:
  - adds outputs stat_resolved[31:0] and stat_mispred[31:0].
  - they increment on each resolve and each mispredict, saturate at all-ones, and reset to 0.
  - $display of PC, prediction and outcome on each mispredict in simulation.
- When undefined: no ports, counters or displays exist, and the core timing is identical.

Decomposition:
- Shared include brq_defs.vh:
  - PC_LEN default.
  - entry field offsets and widths (PC, TKN, TRG_PC) and ENTRY_LEN.
  - state encodings ST_RUN and ST_FLUSH.
- Sub-module: branch_fifo.
  - Synchronous FIFO: DEPTH x ENTRY_LEN, push, pop, clear, full, empty, count.
  - Wrapped by branch_resolve_queue, which holds the FSM, compare logic and output registers.

Test Plan:
1. Reset, then enqueue pc=0x100 pred_taken=1 target=0x200; resolve ex_taken=1 ex_target=0x200 -> next cycle upd_valid=1, upd_mispred=0, flush=0, occupancy=0.
2. Enqueue 0x100, 0x104 and 0x108, all predicted not taken; resolve 0x100 taken to 0x300 -> flush=1, redirect_pc=0x300, occupancy=0; enq_ready=0 for 2 cycles, then 1.
3. Enqueue pc=0x10C predicted taken; resolve not taken -> flush=1, redirect_pc=0x110, upd_taken=0, upd_mispred=1.
4. Fill 4 entries -> enq_ready=0; the 5th enq_valid is held; resolve correctly with enq_valid high -> the 5th is not accepted that cycle and is accepted the next.
5. ex_valid with the queue empty -> err=2'b01, no upd_valid. Then resolve with ex_pc=0x500 against head 0x100 -> err=2'b11.
6. Resolve pc=0xFFFFFFFC not taken, predicted taken -> redirect_pc=0x0. Assert rstn=0 during FLUSH -> state RUN, flush=0, enq_ready=1 the cycle after release.

Source files
------------

// File: rtl/branch_resolve_queue_pkg.sv
// Shared definitions for the branch resolve queue.
// Entry layout is {pc, pred_taken, pred_target}; target in the LSBs.
package branch_resolve_queue_pkg;

   localparam int PC_LEN_DEF = 32;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } brq_state_e;

   function automatic int trg_off(input int pc_len);
      return 0;
   endfunction

   function automatic int tkn_off(input int pc_len);
      return pc_len;
   endfunction

   function automatic int pc_off(input int pc_len);
      return pc_len + 1;
   endfunction

   function automatic int entry_len(input int pc_len);
      return 2 * pc_len + 1;
   endfunction

endpackage

// File: rtl/branch_resolve_queue_fifo.sv
// In-order storage for predicted branches.
// Clear wins over push/pop so a squash empties it in one cycle.
module branch_fifo
   import branch_resolve_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = entry_len(PC_LEN_DEF)
)(
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic                     i_clear,
   input  logic [W-1:0]             i_wdata,
   output logic [W-1:0]             o_rdata,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [AW:0]   r_cnt;
   logic          w_push;
   logic          w_pop;

   assign o_full  = (r_cnt == (AW+1)'(DEPTH));
   assign o_empty = (r_cnt == '0);
   assign o_count = r_cnt;
   assign o_rdata = r_mem[r_rp];
   assign w_push  = i_push && !o_full && !i_clear;
   assign w_pop   = i_pop && !o_empty && !i_clear;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wp] <= i_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn || i_clear) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) begin
            r_wp <= r_wp + AW'(1);
         end
         if (w_pop) begin
            r_rp <= r_rp + AW'(1);
         end
         r_cnt <= r_cnt + {{AW{1'b0}}, w_push}
                        - {{AW{1'b0}}, w_pop};
      end
   end

endmodule

// File: rtl/branch_resolve_queue.sv
// Tracks predicted branches, compares them with execute and squashes on mispredict.
// Optional BRQ_STATS_EN adds resolve/mispredict counters and a mispredict trace.
module branch_resolve_queue
   import branch_resolve_queue_pkg::*;
#(
   parameter int PC_LEN       = PC_LEN_DEF,
   parameter int DEPTH        = 4,
   parameter int FLUSH_CYCLES = 2
)(
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     enq_valid,
   output logic                     enq_ready,
   input  logic [PC_LEN-1:0]        enq_pc,
   input  logic                     enq_pred_taken,
   input  logic [PC_LEN-1:0]        enq_pred_target,
   input  logic                     ex_valid,
   input  logic [PC_LEN-1:0]        ex_pc,
   input  logic                     ex_taken,
   input  logic [PC_LEN-1:0]        ex_target,
   output logic                     upd_valid,
   output logic [PC_LEN-1:0]        upd_pc,
   output logic                     upd_taken,
   output logic [PC_LEN-1:0]        upd_target,
   output logic                     upd_mispred,
   output logic                     flush,
   output logic [PC_LEN-1:0]        redirect_pc,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic [1:0]               err
`ifdef BRQ_STATS_EN
   ,
   output logic [31:0]              stat_resolved,
   output logic [31:0]              stat_mispred
`endif
);

   localparam int ENTRY_LEN = entry_len(PC_LEN);
   localparam int OFF_PC    = pc_off(PC_LEN);
   localparam int OFF_TKN   = tkn_off(PC_LEN);
   localparam int OFF_TRG   = trg_off(PC_LEN);
   localparam int CW        = $clog2(FLUSH_CYCLES + 1);

   brq_state_e            r_state;
   brq_state_e            w_state_nxt;
   logic [CW-1:0]         r_cnt;
   logic [CW-1:0]         w_cnt_nxt;

   logic                  w_run;
   logic                  w_full;
   logic                  w_empty;
   logic [ENTRY_LEN-1:0]  w_enq_data;
   logic [ENTRY_LEN-1:0]  w_head;
   logic [PC_LEN-1:0]     w_head_pc;
   logic                  w_head_tkn;
   logic [PC_LEN-1:0]     w_head_trg;
   logic                  w_res;
   logic                  w_mis;
   logic                  w_mis_res;
   logic                  w_push;
   logic                  w_underflow;

   logic                  r_upd_valid;
   logic [PC_LEN-1:0]     r_upd_pc;
   logic                  r_upd_taken;
   logic [PC_LEN-1:0]     r_upd_target;
   logic                  r_upd_mispred;
   logic                  r_flush;
   logic [PC_LEN-1:0]     r_redirect;
   logic [1:0]            r_err;

   assign w_enq_data = {enq_pc, enq_pred_taken, enq_pred_target};
   assign w_head_pc  = w_head[OFF_PC +: PC_LEN];
   assign w_head_tkn = w_head[OFF_TKN];
   assign w_head_trg = w_head[OFF_TRG +: PC_LEN];

   assign enq_ready   = w_run && !w_full;
   assign w_res       = ex_valid && w_run && !w_empty;
   assign w_underflow = ex_valid && w_run && w_empty;
   assign w_mis       = (w_head_tkn != ex_taken)
                     || (ex_taken && (w_head_trg != ex_target));
   assign w_mis_res   = w_res && w_mis;
   // An enqueue racing a squash is younger than the bad branch.
   assign w_push      = enq_valid && enq_ready && !w_mis_res;

   branch_fifo #(
      .DEPTH   (DEPTH),
      .W       (ENTRY_LEN)
   ) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .i_push  (w_push),
      .i_pop   (w_res),
      .i_clear (w_mis_res),
      .i_wdata (w_enq_data),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (occupancy)
   );

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state <= ST_RUN;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      unique case (r_state)
         ST_RUN: begin
            if (w_mis_res) begin
               w_state_nxt = ST_FLUSH;
               w_cnt_nxt   = CW'(FLUSH_CYCLES);
            end
         end
         ST_FLUSH: begin
            if (r_cnt == CW'(1)) begin
               w_state_nxt = ST_RUN;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt   = r_cnt - CW'(1);
            end
         end
         default: begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      w_run = (r_state == ST_RUN);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_upd_valid   <= 1'b0;
         r_upd_pc      <= '0;
         r_upd_taken   <= 1'b0;
         r_upd_target  <= '0;
         r_upd_mispred <= 1'b0;
         r_flush       <= 1'b0;
         r_redirect    <= '0;
         r_err         <= 2'b00;
      end else begin
         r_upd_valid   <= w_res;
         r_upd_mispred <= w_mis_res;
         r_flush       <= w_mis_res;
         if (w_res) begin
            r_upd_pc     <= ex_pc;
            r_upd_taken  <= ex_taken;
            r_upd_target <= ex_target;
         end
         if (w_mis_res) begin
            r_redirect <= ex_taken ? ex_target
                                   : ex_pc + PC_LEN'(4);
         end
         r_err[0] <= r_err[0] | w_underflow;
         r_err[1] <= r_err[1] | (w_res && (ex_pc != w_head_pc));
      end
   end

   assign upd_valid   = r_upd_valid;
   assign upd_pc      = r_upd_pc;
   assign upd_taken   = r_upd_taken;
   assign upd_target  = r_upd_target;
   assign upd_mispred = r_upd_mispred;
   assign flush       = r_flush;
   assign redirect_pc = r_redirect;
   assign err         = r_err;

`ifdef BRQ_STATS_EN
   logic [31:0] r_stat_res;
   logic [31:0] r_stat_mis;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_stat_res <= '0;
         r_stat_mis <= '0;
      end else begin
         if (w_res && (r_stat_res != '1)) begin
            r_stat_res <= r_stat_res + 32'd1;
         end
         if (w_mis_res && (r_stat_mis != '1)) begin
            r_stat_mis <= r_stat_mis + 32'd1;
         end
      end
   end

   assign stat_resolved = r_stat_res;
   assign stat_mispred  = r_stat_mis;

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (rstn && w_mis_res) begin
         $display("[BRQ] mispredict pc=%h pred=%b/%h act=%b/%h",
                  ex_pc, w_head_tkn, w_head_trg, ex_taken, ex_target);
      end
   end
`endif
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench for branch_resolve_queue: directed scenarios
// plus randomized traffic against a queue-based reference model.
module tb_branch_resolve_queue;

   localparam int PCL = 32;
   localparam int DEP = 4;
   localparam int FLC = 2;

   logic            clk = 1'b0;
   logic            rstn;
   logic            enq_valid;
   logic            enq_ready;
   logic [PCL-1:0]  enq_pc;
   logic            enq_pred_taken;
   logic [PCL-1:0]  enq_pred_target;
   logic            ex_valid;
   logic [PCL-1:0]  ex_pc;
   logic            ex_taken;
   logic [PCL-1:0]  ex_target;
   logic            upd_valid;
   logic [PCL-1:0]  upd_pc;
   logic            upd_taken;
   logic [PCL-1:0]  upd_target;
   logic            upd_mispred;
   logic            flush;
   logic [PCL-1:0]  redirect_pc;
   logic [2:0]      occupancy;
   logic [1:0]      err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   branch_resolve_queue #(
      .PC_LEN          (PCL),
      .DEPTH           (DEP),
      .FLUSH_CYCLES    (FLC)
   ) dut (
      .clk             (clk),
      .rstn            (rstn),
      .enq_valid       (enq_valid),
      .enq_ready       (enq_ready),
      .enq_pc          (enq_pc),
      .enq_pred_taken  (enq_pred_taken),
      .enq_pred_target (enq_pred_target),
      .ex_valid        (ex_valid),
      .ex_pc           (ex_pc),
      .ex_taken        (ex_taken),
      .ex_target       (ex_target),
      .upd_valid       (upd_valid),
      .upd_pc          (upd_pc),
      .upd_taken       (upd_taken),
      .upd_target      (upd_target),
      .upd_mispred     (upd_mispred),
      .flush           (flush),
      .redirect_pc     (redirect_pc),
      .occupancy       (occupancy),
      .err             (err)
   );

   typedef struct {
      logic [PCL-1:0] pc;
      logic           pt;
      logic [PCL-1:0] tg;
   } ent_t;

   ent_t           mq[$];
   int             m_fl;
   logic [1:0]     m_err;
   logic           e_uv, e_um, e_fl, e_ut;
   logic [PCL-1:0] e_upc, e_utg, e_rd;

   function automatic bit m_ready();
      return (m_fl == 0) && (mq.size() < DEP);
   endfunction

   task automatic model_reset();
      mq.delete();
      m_fl  = 0;
      m_err = 2'b00;
      e_uv  = 0; e_um = 0; e_fl = 0; e_ut = 0;
      e_upc = '0; e_utg = '0; e_rd = '0;
   endtask

   task automatic model_step();
      bit   run, rdy, res, mis;
      ent_t n;
      run = (m_fl == 0);
      rdy = m_ready();
      res = ex_valid && run && (mq.size() > 0);
      mis = 0;
      if (ex_valid && run && mq.size() == 0) m_err[0] = 1'b1;
      if (res) begin
         mis = (mq[0].pt != ex_taken) ||
               (ex_taken && mq[0].tg != ex_target);
         if (mq[0].pc != ex_pc) m_err[1] = 1'b1;
         e_upc = ex_pc; e_ut = ex_taken; e_utg = ex_target;
      end
      e_uv = res;
      e_um = res && mis;
      e_fl = res && mis;
      if (res && mis) e_rd = ex_taken ? ex_target : ex_pc + 32'd4;
      if (res && mis) m_fl = FLC;
      else if (m_fl > 0) m_fl--;
      if (res) begin
         void'(mq.pop_front());
         if (mis) mq.delete();
      end
      if (enq_valid && rdy && !(res && mis)) begin
         n.pc = enq_pc; n.pt = enq_pred_taken; n.tg = enq_pred_target;
         mq.push_back(n);
      end
   endtask

   task automatic tick();
      if (!rstn) model_reset();
      else model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      enq_valid = 0; ex_valid = 0;
   endtask

   task automatic enq(input logic [PCL-1:0] pc, input logic pt,
                      input logic [PCL-1:0] tg);
      ex_valid = 0;
      enq_valid = 1; enq_pc = pc;
      enq_pred_taken = pt; enq_pred_target = tg;
      tick();
      enq_valid = 0;
   endtask

   task automatic resolve(input logic [PCL-1:0] pc, input logic tk,
                          input logic [PCL-1:0] tg);
      ex_valid = 1; ex_pc = pc; ex_taken = tk; ex_target = tg;
      tick();
      ex_valid = 0;
   endtask

   task automatic do_reset();
      idle();
      rstn = 0;
      tick();
      tick();
      rstn = 1;
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++;
      if ({upd_valid, upd_mispred, flush, upd_taken} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_strobes got %b exp 0000",
                  {upd_valid, upd_mispred, flush, upd_taken});
      end
      n_tests++;
      if (occupancy !== 3'd0 || err !== 2'b00 || enq_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_state occ=%0d err=%b rdy=%b exp 0 00 1",
                  occupancy, err, enq_ready);
      end
      n_tests++;
      if (upd_pc !== 0 || upd_target !== 0 || redirect_pc !== 0) begin
         n_fail++;
         $display("FAIL reset_pcs got %h %h %h exp 0",
                  upd_pc, upd_target, redirect_pc);
      end
   endtask

   task automatic test_correct();
      enq(32'h100, 1'b1, 32'h200);
      resolve(32'h100, 1'b1, 32'h200);
      n_tests++;
      if ({upd_valid, upd_mispred, flush} !== 3'b100 || occupancy !== 0) begin
         n_fail++;
         $display("FAIL correct_upd v/m/f=%b occ=%0d exp 100 0",
                  {upd_valid, upd_mispred, flush}, occupancy);
      end
      n_tests++;
      if (upd_pc !== 32'h100 || upd_taken !== 1'b1 || upd_target !== 32'h200) begin
         n_fail++;
         $display("FAIL correct_fields got %h %b %h exp 100 1 200",
                  upd_pc, upd_taken, upd_target);
      end
      tick();
      n_tests++;
      if (upd_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL correct_one_shot upd_valid=%b exp 0", upd_valid);
      end
   endtask

   task automatic test_mispred_taken();
      enq(32'h100, 1'b0, 32'h0);
      enq(32'h104, 1'b0, 32'h0);
      enq(32'h108, 1'b0, 32'h0);
      resolve(32'h100, 1'b1, 32'h300);
      n_tests++;
      if (flush !== 1'b1 || redirect_pc !== 32'h300 || occupancy !== 0) begin
         n_fail++;
         $display("FAIL mt_flush f=%b rd=%h occ=%0d exp 1 300 0",
                  flush, redirect_pc, occupancy);
      end
      n_tests++;
      if (enq_ready !== 1'b0 || upd_mispred !== 1'b1) begin
         n_fail++;
         $display("FAIL mt_rdy0 rdy=%b mis=%b exp 0 1", enq_ready, upd_mispred);
      end
      enq_valid = 1; enq_pc = 32'h900;
      ex_valid = 1; ex_pc = 32'h104;
      tick();
      idle();
      n_tests++;
      if (enq_ready !== 1'b0 || flush !== 1'b0 || upd_valid !== 1'b0
          || occupancy !== 0) begin
         n_fail++;
         $display("FAIL mt_rdy1 rdy=%b f=%b uv=%b occ=%0d exp 0 0 0 0",
                  enq_ready, flush, upd_valid, occupancy);
      end
      tick();
      n_tests++;
      if (enq_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL mt_rdy2 rdy=%b exp 1", enq_ready);
      end
   endtask

   task automatic test_mispred_not_taken();
      enq(32'h10C, 1'b1, 32'h999);
      resolve(32'h10C, 1'b0, 32'h0);
      n_tests++;
      if (flush !== 1'b1 || redirect_pc !== 32'h110 || upd_taken !== 1'b0
          || upd_mispred !== 1'b1) begin
         n_fail++;
         $display("FAIL mnt got f=%b rd=%h tk=%b mis=%b exp 1 110 0 1",
                  flush, redirect_pc, upd_taken, upd_mispred);
      end
      tick();
      tick();
   endtask

   task automatic test_full();
      for (int i = 0; i < DEP; i++) enq(32'h200 + 32'(4*i), 1'b0, 32'h0);
      n_tests++;
      if (enq_ready !== 1'b0 || occupancy !== 3'd4) begin
         n_fail++;
         $display("FAIL full_rdy rdy=%b occ=%0d exp 0 4", enq_ready, occupancy);
      end
      enq_valid = 1; enq_pc = 32'h210;
      enq_pred_taken = 1'b0; enq_pred_target = 32'h0;
      ex_valid = 1; ex_pc = 32'h200; ex_taken = 1'b0; ex_target = 32'h0;
      #1;
      n_tests++;
      if (enq_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL full_nobypass rdy=%b exp 0", enq_ready);
      end
      tick();
      ex_valid = 0;
      n_tests++;
      if (occupancy !== 3'd3 || enq_ready !== 1'b1 || upd_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL full_pop occ=%0d rdy=%b uv=%b exp 3 1 1",
                  occupancy, enq_ready, upd_valid);
      end
      tick();
      enq_valid = 0;
      n_tests++;
      if (occupancy !== 3'd4 || mq.size() != 4 || mq[3].pc != 32'h210) begin
         n_fail++;
         $display("FAIL full_fifth occ=%0d exp 4", occupancy);
      end
      for (int k = 0; k < 2 * DEP && mq.size() > 0; k++) begin
         resolve(mq[0].pc, mq[0].pt, mq[0].tg);
         n_tests++;
         if (upd_valid !== 1'b1 || upd_mispred !== 1'b0 || upd_pc !== e_upc
             || occupancy !== 3'(mq.size())) begin
            n_fail++;
            $display("FAIL full_drain uv=%b mis=%b pc=%h occ=%0d exp 1 0 %h %0d",
                     upd_valid, upd_mispred, upd_pc, occupancy, e_upc, mq.size());
         end
      end
   endtask

   task automatic test_err();
      do_reset();
      resolve(32'h100, 1'b0, 32'h0);
      n_tests++;
      if (err !== 2'b01 || upd_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL err_under err=%b uv=%b exp 01 0", err, upd_valid);
      end
      enq(32'h100, 1'b0, 32'h0);
      resolve(32'h500, 1'b0, 32'h0);
      n_tests++;
      if (err !== 2'b11 || upd_valid !== 1'b1 || upd_pc !== 32'h500
          || upd_mispred !== 1'b0 || occupancy !== 0) begin
         n_fail++;
         $display("FAIL err_order err=%b uv=%b pc=%h mis=%b occ=%0d exp 11 1 500 0 0",
                  err, upd_valid, upd_pc, upd_mispred, occupancy);
      end
      tick();
      n_tests++;
      if (err !== 2'b11) begin
         n_fail++;
         $display("FAIL err_sticky err=%b exp 11", err);
      end
   endtask

   task automatic test_wrap_reset();
      do_reset();
      enq(32'hFFFF_FFFC, 1'b1, 32'h40);
      enq(32'h0, 1'b0, 32'h0);
      resolve(32'hFFFF_FFFC, 1'b0, 32'h0);
      n_tests++;
      if (flush !== 1'b1 || redirect_pc !== 32'h0 || occupancy !== 0) begin
         n_fail++;
         $display("FAIL wrap_rd f=%b rd=%h occ=%0d exp 1 0 0",
                  flush, redirect_pc, occupancy);
      end
      rstn = 0;
      tick();
      rstn = 1;
      n_tests++;
      if (flush !== 1'b0 || enq_ready !== 1'b1 || err !== 2'b00
          || occupancy !== 0) begin
         n_fail++;
         $display("FAIL wrap_rst f=%b rdy=%b err=%b occ=%0d exp 0 1 00 0",
                  flush, enq_ready, err, occupancy);
      end
      enq(32'h700, 1'b0, 32'h0);
      n_tests++;
      if (occupancy !== 3'd1) begin
         n_fail++;
         $display("FAIL wrap_enq occ=%0d exp 1", occupancy);
      end
   endtask

   task automatic test_random();
      logic [PCL-1:0] tgs[2];
      tgs[0] = 32'h1000;
      tgs[1] = 32'h2000;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         enq_valid       = ($urandom_range(0, 2) != 0);
         enq_pc          = {$urandom_range(0, 255), 2'b00};
         enq_pred_taken  = $urandom_range(0, 1);
         enq_pred_target = tgs[$urandom_range(0, 1)];
         ex_valid        = ($urandom_range(0, 1) != 0);
         if (mq.size() > 0 && $urandom_range(0, 19) != 0) begin
            ex_pc     = mq[0].pc;
            ex_taken  = ($urandom_range(0, 3) != 0) ? mq[0].pt
                                                    : $urandom_range(0, 1);
            ex_target = ($urandom_range(0, 3) != 0) ? mq[0].tg
                                                    : tgs[$urandom_range(0, 1)];
         end else begin
            ex_pc     = {$urandom_range(0, 255), 2'b00};
            ex_taken  = $urandom_range(0, 1);
            ex_target = tgs[$urandom_range(0, 1)];
         end
         #1;
         n_tests++;
         if (enq_ready !== m_ready()) begin
            n_fail++;
            $display("FAIL rnd_rdy c=%0d got %b exp %b", c, enq_ready, m_ready());
         end
         tick();
         n_tests++;
         if ({upd_valid, upd_mispred, flush} !== {e_uv, e_um, e_fl}
             || occupancy !== 3'(mq.size()) || err !== m_err) begin
            n_fail++;
            $display("FAIL rnd_ctl c=%0d v/m/f=%b occ=%0d err=%b exp %b %0d %b",
                     c, {upd_valid, upd_mispred, flush}, occupancy, err,
                     {e_uv, e_um, e_fl}, mq.size(), m_err);
         end
         if (e_uv) begin
            n_tests++;
            if (upd_pc !== e_upc || upd_taken !== e_ut || upd_target !== e_utg) begin
               n_fail++;
               $display("FAIL rnd_upd c=%0d got %h %b %h exp %h %b %h",
                        c, upd_pc, upd_taken, upd_target, e_upc, e_ut, e_utg);
            end
         end
         if (e_fl) begin
            n_tests++;
            if (redirect_pc !== e_rd) begin
               n_fail++;
               $display("FAIL rnd_redirect c=%0d got %h exp %h", c, redirect_pc, e_rd);
            end
         end
      end
      idle();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn = 0;
      enq_valid = 0; enq_pc = '0; enq_pred_taken = 0; enq_pred_target = '0;
      ex_valid = 0; ex_pc = '0; ex_taken = 0; ex_target = '0;
      model_reset();
      test_reset();
      test_correct();
      test_mispred_taken();
      test_mispred_not_taken();
      test_full();
      test_err();
      test_wrap_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
